// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers upstream samples and paces the fir input.
// Each frame ends with N_TAPS-1 zero beats, LATENCY drain beats, frame_done.
module fir_sample_feeder #(
  parameter int DW       = 18,
  parameter int DEPTH    = 16,
  parameter int N_TAPS   = 11,
  parameter int LATENCY  = 12,
  parameter int RATE_DIV = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          fir_clk_ena,
  output logic          fir_i_valid,
  output logic [DW-1:0] fir_i_in,
  output logic          frame_done,
  output logic          busy
);

  localparam int AW   = $clog2(DEPTH);
  localparam int NW   = AW + 1;
  localparam int MAXC = (N_TAPS > LATENCY) ? N_TAPS : LATENCY;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DVW  = $clog2(RATE_DIV + 1);

  localparam logic [NW-1:0]  FULL_N   = NW'(DEPTH);
  localparam logic [CW-1:0]  FLUSH_N  = CW'(N_TAPS - 1);
  localparam logic [CW-1:0]  DRAIN_N  = CW'(LATENCY);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [DVW-1:0] DIV_LAST = DVW'(RATE_DIV - 1);

  typedef enum logic [1:0] {
    ST_STREAM,
    ST_FLUSH,
    ST_DRAIN
  } state_t;

  // FIFO storage and bookkeeping
  logic [DW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q;
  logic [AW-1:0]  rd_ptr_q;
  logic [NW-1:0]  count_q;
  logic [NW-1:0]  count_d;
  logic           s_ready_q;

  // one-entry holding stage between FIFO and beat logic
  logic           s1_vld_q;
  logic           s1_last_q;
  logic [DW-1:0]  s1_data_q;

  // beat pacing and sequencing
  logic [DVW-1:0] div_q;
  state_t         state_q;
  logic [CW-1:0]  cnt_q;

  // registered fir-side outputs
  logic           ena_q;
  logic           vld_q;
  logic [DW-1:0]  in_q;
  logic           done_q;

  logic push;
  logic pop;
  logic slot;
  logic consume;
  logic beat;
  logic refill_ok;
  logic fifo_empty;

  assign push       = s_valid && s_ready_q;
  assign fifo_empty = (count_q == '0);
  assign slot       = (div_q == '0);

  assign consume = (state_q == ST_STREAM)
                && slot && s1_vld_q;

  assign beat = consume
             || (slot && (state_q != ST_STREAM));

  // the stage refills only while streaming and
  // never right behind the last sample of a frame
  assign refill_ok = (state_q == ST_STREAM)
                  && (!s1_vld_q
                   || (consume && !s1_last_q));

  assign pop = refill_ok && !fifo_empty;

  assign count_d = count_q
                 + NW'(push)
                 - NW'(pop);

  // FIFO storage write port, no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_last, s_data};
    end
  end

  // FIFO pointers, occupancy and registered ready
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q   <= count_d;
      s_ready_q <= (count_d != FULL_N);
    end
  end

  // holding stage: loaded on pop, emptied when its beat goes out
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      s1_data_q <= '0;
    end else if (pop) begin
      s1_vld_q  <= 1'b1;
      s1_last_q <= mem_q[rd_ptr_q][DW];
      s1_data_q <= mem_q[rd_ptr_q][DW-1:0];
    end else if (consume) begin
      s1_vld_q  <= 1'b0;
    end
  end

  // rate divider: parks on the slot until a beat uses it,
  // so consecutive beats are at least RATE_DIV cycles apart
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q <= '0;
    end else if (slot && !beat) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DVW'(1);
    end
  end

  // frame sequencer with registered fir-side outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STREAM;
      cnt_q   <= '0;
      ena_q   <= 1'b0;
      vld_q   <= 1'b0;
      in_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      ena_q  <= beat;
      vld_q  <= beat && (state_q != ST_DRAIN);
      done_q <= 1'b0;
      unique case (state_q)
        ST_STREAM: begin
          if (consume) begin
            in_q <= s1_data_q;
            if (s1_last_q) begin
              if (N_TAPS > 1) begin
                state_q <= ST_FLUSH;
                cnt_q   <= FLUSH_N;
              end else begin
                state_q <= ST_DRAIN;
                cnt_q   <= DRAIN_N;
              end
            end
          end
        end
        ST_FLUSH: begin
          if (beat) begin
            in_q <= '0;
            if (cnt_q == CNT_ONE) begin
              state_q <= ST_DRAIN;
              cnt_q   <= DRAIN_N;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          if (beat) begin
            in_q <= '0;
            if (cnt_q == CNT_ONE) begin
              state_q <= ST_STREAM;
              cnt_q   <= '0;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
        end
        default: begin
          state_q <= ST_STREAM;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign s_ready     = s_ready_q;
  assign fir_clk_ena = ena_q;
  assign fir_i_valid = vld_q;
  assign fir_i_in    = in_q;
  assign frame_done  = done_q;

  assign busy = (state_q != ST_STREAM)
             || !fifo_empty
             || s1_vld_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb_fir_sample_feeder: directed bench for fir_sample_feeder.
// dut_a runs with RATE_DIV=1, dut_b with RATE_DIV=3.
module tb_fir_sample_feeder;

  localparam int DW = 18;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic          a_valid = 1'b0;
  logic          a_last  = 1'b0;
  logic [DW-1:0] a_data  = '0;
  logic          a_ready, a_ena, a_vld, a_fd, a_busy;
  logic [DW-1:0] a_in;

  logic          b_valid = 1'b0;
  logic          b_last  = 1'b0;
  logic [DW-1:0] b_data  = '0;
  logic          b_ready, b_ena, b_vld, b_fd, b_busy;
  logic [DW-1:0] b_in;

  fir_sample_feeder #(.DW(DW), .RATE_DIV(1)) dut_a (
    .clk(clk), .reset(reset),
    .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .s_last(a_last),
    .fir_clk_ena(a_ena), .fir_i_valid(a_vld),
    .fir_i_in(a_in), .frame_done(a_fd),
    .busy(a_busy)
  );

  fir_sample_feeder #(.DW(DW), .RATE_DIV(3)) dut_b (
    .clk(clk), .reset(reset),
    .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_last(b_last),
    .fir_clk_ena(b_ena), .fir_i_valid(b_vld),
    .fir_i_in(b_in), .frame_done(b_fd),
    .busy(b_busy)
  );

  int vecs = 0;
  int errs = 0;

  logic          log_en = 1'b0;
  logic          la_ena[$], la_vld[$], la_fd[$];
  logic [DW-1:0] la_in[$];
  logic          lb_ena[$], lb_vld[$], lb_fd[$];
  logic [DW-1:0] lb_in[$];

  // per-cycle trace of both DUTs, sampled mid-cycle
  always @(negedge clk) begin
    if (log_en) begin
      la_ena.push_back(a_ena);
      la_vld.push_back(a_vld);
      la_fd.push_back(a_fd);
      la_in.push_back(a_in);
      lb_ena.push_back(b_ena);
      lb_vld.push_back(b_vld);
      lb_fd.push_back(b_fd);
      lb_in.push_back(b_in);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1, "watchdog");
  end

  task automatic clear_log;
    la_ena.delete(); la_vld.delete();
    la_fd.delete();  la_in.delete();
    lb_ena.delete(); lb_vld.delete();
    lb_fd.delete();  lb_in.delete();
  endtask

  // offer one sample; returns after the edge that takes it
  task automatic push(input int which, input int val,
                      input logic last, output int waited);
    logic rdy;
    logic done;
    waited = 0;
    done = 1'b0;
    if (which == 0) begin
      a_valid = 1'b1; a_data = DW'(val); a_last = last;
    end else begin
      b_valid = 1'b1; b_data = DW'(val); b_last = last;
    end
    while (!done) begin
      @(negedge clk);
      rdy = (which == 0) ? a_ready : b_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          vecs++; errs++;
          $display("FAIL push_timeout: val %0d not taken, want taken", val);
          done = 1'b1;
        end
      end
    end
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vecs++;
      if ({a_ready, a_ena, a_vld, a_in, a_fd, a_busy} !== '0) begin
        errs++;
        $display("FAIL reset_outs_a: got rdy%b ena%b vld%b in%0d fd%b busy%b want all 0",
                 a_ready, a_ena, a_vld, a_in, a_fd, a_busy);
      end
      vecs++;
      if ({b_ready, b_ena, b_vld, b_in, b_fd, b_busy} !== '0) begin
        errs++;
        $display("FAIL reset_outs_b: got rdy%b ena%b busy%b want all 0",
                 b_ready, b_ena, b_busy);
      end
    end
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({a_ready, a_busy, b_ready, b_busy} !== 4'b1010) begin
      errs++;
      $display("FAIL reset_release: got rdy_a%b busy_a%b rdy_b%b busy_b%b want 1 0 1 0",
               a_ready, a_busy, b_ready, b_busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_frame;
    int w, first, idx, fdn, enan;
    logic ev;
    int ei;
    clear_log();
    log_en = 1'b1;
    for (int i = 1; i <= 5; i++) push(0, i, (i == 5), w);
    repeat (40) @(posedge clk);
    #1 log_en = 1'b0;
    first = -1; fdn = 0; enan = 0;
    for (int i = 0; i < la_ena.size(); i++) begin
      if (la_ena[i] && first < 0) first = i;
      if (la_fd[i]) fdn++;
      if (la_ena[i]) enan++;
    end
    vecs++;
    if (first !== 3) begin
      errs++;
      $display("FAIL frame_latency: first beat cycle %0d want 3", first);
    end
    if (first < 0) first = 0;
    for (int j = 0; j < 27; j++) begin
      idx = first + j;
      ev = (j < 15);
      ei = (j < 5) ? j + 1 : 0;
      vecs++;
      if ({la_ena[idx], la_vld[idx], la_in[idx]} !== {1'b1, ev, DW'(ei)}) begin
        errs++;
        $display("FAIL frame_beat%0d: got ena%b vld%b in%0d want ena1 vld%b in%0d",
                 j, la_ena[idx], la_vld[idx], la_in[idx], ev, ei);
      end
    end
    vecs++;
    if (la_ena[first + 27] !== 1'b0 || enan !== 27) begin
      errs++;
      $display("FAIL frame_total: got %0d beats want 27 contiguous", enan);
    end
    vecs++;
    if (la_fd[first + 26] !== 1'b1 || fdn !== 1) begin
      errs++;
      $display("FAIL frame_done: got fd%b at last drain, %0d pulses want 1 and 1",
               la_fd[first + 26], fdn);
    end
    vecs++;
    if (a_busy !== 1'b0) begin
      errs++;
      $display("FAIL frame_idle_busy: got %b want 0", a_busy);
    end
  endtask

  task automatic test_back_to_back;
    int w, stall, n, fdn;
    int seen[$];
    clear_log();
    log_en = 1'b1;
    stall = -1;
    push(0, 100, 1'b1, w);
    for (int i = 0; i < 20; i++) begin
      push(0, 201 + i, (i == 19), w);
      if (w > 0 && stall < 0) stall = i;
    end
    repeat (80) @(posedge clk);
    #1 log_en = 1'b0;
    vecs++;
    if (stall !== 16) begin
      errs++;
      $display("FAIL bp_stall_point: first held-off index %0d want 16", stall);
    end
    fdn = 0;
    for (int i = 0; i < la_ena.size(); i++) begin
      if (la_vld[i] && la_in[i] != '0) seen.push_back(int'(la_in[i]));
      if (la_fd[i]) fdn++;
    end
    vecs++;
    if (seen.size() !== 21) begin
      errs++;
      $display("FAIL bp_count: got %0d data beats want 21", seen.size());
    end
    n = (seen.size() < 21) ? seen.size() : 21;
    for (int i = 0; i < n; i++) begin
      vecs++;
      if (seen[i] !== ((i == 0) ? 100 : 200 + i)) begin
        errs++;
        $display("FAIL bp_order%0d: got %0d want %0d",
                 i, seen[i], (i == 0) ? 100 : 200 + i);
      end
    end
    vecs++;
    if (fdn !== 2) begin
      errs++;
      $display("FAIL bp_frame_done: got %0d pulses want 2", fdn);
    end
  endtask

  task automatic test_gap;
    int w, first, ena_gap, b4;
    int seen[$];
    clear_log();
    log_en = 1'b1;
    for (int i = 1; i <= 3; i++) push(0, i, 1'b0, w);
    repeat (4) @(posedge clk);
    #1;
    push(0, 4, 1'b0, w);
    push(0, 5, 1'b1, w);
    repeat (40) @(posedge clk);
    #1 log_en = 1'b0;
    first = -1; b4 = -1;
    for (int i = 0; i < la_ena.size(); i++) begin
      if (la_ena[i] && first < 0) first = i;
      if (la_vld[i] && la_in[i] != '0) seen.push_back(int'(la_in[i]));
      if (la_vld[i] && la_in[i] == DW'(4) && b4 < 0) b4 = i;
    end
    vecs++;
    if (first !== 3 || b4 !== 10) begin
      errs++;
      $display("FAIL gap_timing: got first %0d sample4 %0d want 3 10", first, b4);
    end
    ena_gap = 0;
    for (int i = 6; i <= 9; i++) begin
      if (la_ena[i]) ena_gap++;
      vecs++;
      if (la_in[i] !== DW'(3)) begin
        errs++;
        $display("FAIL gap_hold%0d: got in %0d want 3", i, la_in[i]);
      end
    end
    vecs++;
    if (ena_gap !== 0) begin
      errs++;
      $display("FAIL gap_stall: got %0d beats in gap want 0", ena_gap);
    end
    vecs++;
    if (seen.size() !== 5) begin
      errs++;
      $display("FAIL gap_count: got %0d data beats want 5", seen.size());
    end
    for (int i = 0; i < seen.size() && i < 5; i++) begin
      vecs++;
      if (seen[i] !== i + 1) begin
        errs++;
        $display("FAIL gap_seq%0d: got %0d want %0d", i, seen[i], i + 1);
      end
    end
  endtask

  task automatic test_rate_div;
    int w, maxw, last, nb, badgap, first, bad;
    int seen[$];
    clear_log();
    log_en = 1'b1;
    maxw = 0;
    for (int i = 1; i <= 30; i++) begin
      push(1, i, (i == 30), w);
      if (w > maxw) maxw = w;
    end
    repeat (200) @(posedge clk);
    #1 log_en = 1'b0;
    nb = 0; badgap = 0; last = -1; first = -1;
    for (int i = 0; i < lb_ena.size(); i++) begin
      if (lb_ena[i]) begin
        nb++;
        if (first < 0) first = i;
        if (last >= 0 && i - last != 3) badgap++;
        last = i;
      end
      if (lb_vld[i] && lb_in[i] != '0) seen.push_back(int'(lb_in[i]));
    end
    vecs++;
    if (first !== 3) begin
      errs++;
      $display("FAIL div_latency: first beat %0d want 3", first);
    end
    vecs++;
    if (nb !== 52) begin
      errs++;
      $display("FAIL div_beats: got %0d beats want 52", nb);
    end
    vecs++;
    if (badgap !== 0) begin
      errs++;
      $display("FAIL div_spacing: got %0d gaps not 3 want 0", badgap);
    end
    vecs++;
    if (maxw == 0) begin
      errs++;
      $display("FAIL div_full: got no backpressure want s_ready low when full");
    end
    bad = (seen.size() == 30) ? 0 : 1;
    for (int i = 0; i < seen.size() && i < 30; i++)
      if (seen[i] != i + 1) bad++;
    vecs++;
    if (bad !== 0) begin
      errs++;
      $display("FAIL div_order: got %0d errors in 1..30 sequence want 0", bad);
    end
  endtask

  task automatic test_reset_drain;
    int w, n, cyc, fdn, first, enan;
    push(0, 50, 1'b1, w);
    n = 0; cyc = 0;
    while (n < 5 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_ena && !a_vld) n++;
    end
    vecs++;
    if (n !== 5) begin
      errs++;
      $display("FAIL rd_drain_seen: got %0d drain beats want 5", n);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vecs++;
    if ({a_ena, a_vld, a_fd, a_busy, a_ready} !== 5'b0) begin
      errs++;
      $display("FAIL rd_in_reset: got ena%b vld%b fd%b busy%b rdy%b want 0",
               a_ena, a_vld, a_fd, a_busy, a_ready);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    fdn = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_fd) fdn++;
    end
    vecs++;
    if (fdn !== 0) begin
      errs++;
      $display("FAIL rd_no_done: got %0d pulses want 0", fdn);
    end
    vecs++;
    if ({a_ready, a_busy} !== 2'b10) begin
      errs++;
      $display("FAIL rd_after: got rdy%b busy%b want 1 0", a_ready, a_busy);
    end
    @(posedge clk);
    #1;
    clear_log();
    log_en = 1'b1;
    push(0, 7, 1'b0, w);
    push(0, 8, 1'b1, w);
    repeat (40) @(posedge clk);
    #1 log_en = 1'b0;
    first = -1; enan = 0; fdn = 0;
    for (int i = 0; i < la_ena.size(); i++) begin
      if (la_ena[i] && first < 0) first = i;
      if (la_ena[i]) enan++;
      if (la_fd[i]) fdn++;
    end
    vecs++;
    if (first !== 3) begin
      errs++;
      $display("FAIL rd_latency: first beat %0d want 3", first);
    end
    if (first < 0) first = 0;
    vecs++;
    if ({la_vld[first], la_in[first], la_vld[first + 1], la_in[first + 1]}
        !== {1'b1, DW'(7), 1'b1, DW'(8)}) begin
      errs++;
      $display("FAIL rd_data: got %0d,%0d want 7,8", la_in[first], la_in[first + 1]);
    end
    vecs++;
    if (enan !== 24 || fdn !== 1 || la_fd[first + 23] !== 1'b1) begin
      errs++;
      $display("FAIL rd_frame: got %0d beats %0d pulses want 24 1", enan, fdn);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_gap();
    test_rate_div();
    test_reset_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
